// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// the hardwired-zero register index and the read-port limit.
package regfile_pkg;

    // Index of the register that always reads zero and never goes pending.
    localparam int REG_ZERO = 0;

    // Largest number of read ports the file is built for.
    localparam int MAX_READ = 8;

    // Address bits needed to select one of 'depth' registers (at least 1).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: selects the stored word, forces register 0 to
// zero and, when bypass is enabled, forwards same-cycle write data with
// write port 1 taking priority over write port 0.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] pending,
    input  logic             wen0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             wen1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic [WIDTH-1:0] data,
    output logic             busy
);

    localparam bit BYPASS_ON = (BYPASS != 0);

    logic hit0;
    logic hit1;

    // Write enables arrive already gated by reset and by the zero register,
    // so a hit here means a real write to this address is happening now.
    always_comb begin
        hit0 = wen0 && (waddr0 == addr);
        hit1 = wen1 && (waddr1 == addr);
    end

    // Read mux: zero register first, then bypass (port 1 over port 0), then storage.
    always_comb begin
        data = regs[addr];
        busy = pending[addr];
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
            busy = 1'b0;
        end else if (BYPASS_ON && hit1) begin
            data = wdata1;
            busy = 1'b0;
        end else if (BYPASS_ON && hit0) begin
            data = wdata0;
            busy = 1'b0;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two write ports (port 1 wins on an
// address collision), NUM_READ combinational read ports with optional
// write-to-read bypass, and a per-register pending scoreboard for hazard
// detection. Register 0 is hardwired to zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic                      ctrl_writeEnable0,
    input  logic [AW-1:0]             ctrl_writeReg0,
    input  logic [WIDTH-1:0]          data_writeReg0,
    input  logic                      ctrl_writeEnable1,
    input  logic [AW-1:0]             ctrl_writeReg1,
    input  logic [WIDTH-1:0]          data_writeReg1,
    input  logic                      ctrl_markPending,
    input  logic [AW-1:0]             ctrl_pendingReg,
    input  logic [NUM_READ*AW-1:0]    ctrl_readReg,
    output logic [NUM_READ*WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]       pending_read
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic             wen0;
    logic             wen1;
    logic             mark_en;
    logic [DEPTH-1:0] wr_hit0;
    logic [DEPTH-1:0] wr_hit1;
    logic [DEPTH-1:0] mark_hit;

    // Effective enables: nothing writes or marks while reset is asserted, and
    // register 0 is filtered out here so every consumer sees the same rule.
    always_comb begin
        wen0    = ctrl_writeEnable0 && ctrl_reset_n && (ctrl_writeReg0 != AW'(REG_ZERO));
        wen1    = ctrl_writeEnable1 && ctrl_reset_n && (ctrl_writeReg1 != AW'(REG_ZERO));
        mark_en = ctrl_markPending  && ctrl_reset_n && (ctrl_pendingReg != AW'(REG_ZERO));
    end

    // One-hot decode of both write addresses and the mark address.
    always_comb begin
        wr_hit0  = '0;
        wr_hit1  = '0;
        mark_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit0[i]  = wen0    && (ctrl_writeReg0  == AW'(i));
            wr_hit1[i]  = wen1    && (ctrl_writeReg1  == AW'(i));
            mark_hit[i] = mark_en && (ctrl_pendingReg == AW'(i));
        end
    end

    // Register storage: port 1 overrides port 0 on a shared address; register 0 stays zero.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == REG_ZERO) begin
                    regs[i] <= '0;
                end else if (wr_hit1[i]) begin
                    regs[i] <= data_writeReg1;
                end else if (wr_hit0[i]) begin
                    regs[i] <= data_writeReg0;
                end
            end
        end
    end

    // Pending scoreboard: a mark beats a same-cycle write; any write clears.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == REG_ZERO) begin
                    pending[i] <= 1'b0;
                end else if (mark_hit[i]) begin
                    pending[i] <= 1'b1;
                end else if (wr_hit0[i] || wr_hit1[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_READ; k++) begin : g_read
            regfile_read_port #(
                .WIDTH  (WIDTH),
                .DEPTH  (DEPTH),
                .BYPASS (BYPASS),
                .AW     (AW)
            ) u_port (
                .addr   (ctrl_readReg[k*AW +: AW]),
                .regs   (regs),
                .pending(pending),
                .wen0   (wen0),
                .waddr0 (ctrl_writeReg0),
                .wdata0 (data_writeReg0),
                .wen1   (wen1),
                .waddr1 (ctrl_writeReg1),
                .wdata1 (data_writeReg1),
                .data   (data_readReg[k*WIDTH +: WIDTH]),
                .busy   (pending_read[k])
            );
        end
    endgenerate

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (bypass on, bypass off,
// and a 16-bit x 8-deep x 3-read-port build) driven with directed vectors.
module tb_regfile_mp;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus for the two 32x32 instances.
    logic        rst_n;
    logic        we0, we1, mk;
    logic [4:0]  wa0, wa1, pr;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd_a, rd_b;
    logic [1:0]  pd_a, pd_b;

    // Stimulus for the 16x8 instance.
    logic        rst_c;
    logic        ce0, ce1, cm;
    logic [2:0]  ca0, ca1, cp;
    logic [15:0] cd0, cd1;
    logic [8:0]  cra;
    logic [47:0] rd_c;
    logic [2:0]  pd_c;

    regfile_mp #(.BYPASS(1)) dut_a (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable0(we0), .ctrl_writeReg0(wa0), .data_writeReg0(wd0),
        .ctrl_writeEnable1(we1), .ctrl_writeReg1(wa1), .data_writeReg1(wd1),
        .ctrl_markPending(mk), .ctrl_pendingReg(pr),
        .ctrl_readReg(ra), .data_readReg(rd_a), .pending_read(pd_a)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .clock(clock), .ctrl_reset_n(rst_n),
        .ctrl_writeEnable0(we0), .ctrl_writeReg0(wa0), .data_writeReg0(wd0),
        .ctrl_writeEnable1(we1), .ctrl_writeReg1(wa1), .data_writeReg1(wd1),
        .ctrl_markPending(mk), .ctrl_pendingReg(pr),
        .ctrl_readReg(ra), .data_readReg(rd_b), .pending_read(pd_b)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(8), .NUM_READ(3), .BYPASS(1)) dut_c (
        .clock(clock), .ctrl_reset_n(rst_c),
        .ctrl_writeEnable0(ce0), .ctrl_writeReg0(ca0), .data_writeReg0(cd0),
        .ctrl_writeEnable1(ce1), .ctrl_writeReg1(ca1), .data_writeReg1(cd1),
        .ctrl_markPending(cm), .ctrl_pendingReg(cp),
        .ctrl_readReg(cra), .data_readReg(rd_c), .pending_read(pd_c)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] d;
        logic        p;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    event  sample_ev;
    int    checks   = 0;
    int    failures = 0;

    task automatic set_ab(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic m, input logic [4:0] p,
                          input logic [4:0] r0, input logic [4:0] r1);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
        mk  = m;  pr  = p;
        ra  = {r1, r0};
    endtask

    task automatic set_c(input logic e0, input logic [2:0] a0, input logic [15:0] d0,
                         input logic e1, input logic [2:0] a1, input logic [15:0] d1,
                         input logic m, input logic [2:0] p,
                         input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
        ce0 = e0; ca0 = a0; cd0 = d0;
        ce1 = e1; ca1 = a1; cd1 = d1;
        cm  = m;  cp  = p;
        cra = {r2, r1, r0};
    endtask

    task automatic expect_one(input int dut, input int port, input logic [31:0] d,
                              input logic p, input string nm);
        exp_t e;
        e.dut = dut; e.port = port; e.d = d; e.p = p;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    // Expectation for both 32-bit instances on one port.
    task automatic expect_ab(input int port, input logic [31:0] da, input logic pa,
                             input logic [31:0] db, input logic pb, input string nm);
        expect_one(0, port, da, pa, {nm, "_byp"});
        expect_one(1, port, db, pb, {nm, "_nobyp"});
    endtask

    // Next stimulus slot: inputs change on the falling edge.
    task automatic slot();
        @(negedge clock);
    endtask

    // Let combinational outputs settle, then the caller pushes expectations.
    task automatic settle();
        #2;
    endtask

    task automatic fire();
        -> sample_ev;
    endtask

    // Monitor: whenever a sample point is announced, drain and compare.
    initial begin
        exp_t        e;
        string       nm;
        logic [31:0] act_d;
        logic        act_p;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e  = q.pop_front();
                nm = qn.pop_front();
                case (e.dut)
                    0:       begin act_d = rd_a[e.port*32 +: 32];        act_p = pd_a[e.port]; end
                    1:       begin act_d = rd_b[e.port*32 +: 32];        act_p = pd_b[e.port]; end
                    default: begin act_d = {16'h0, rd_c[e.port*16 +: 16]}; act_p = pd_c[e.port]; end
                endcase
                checks++;
                if (act_d !== e.d || act_p !== e.p) begin
                    failures++;
                    $display("FAIL %s dut=%0d port=%0d got data=%h pend=%b expected data=%h pend=%b",
                             nm, e.dut, e.port, act_d, act_p, e.d, e.p);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rst_c = 1'b0;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_c (0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);

        // Reset state: every address on both ports reads 0, not pending.
        slot(); rst_n = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i != 0) slot();
            set_ab(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            settle();
            expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "reset_p0");
            expect_ab(1, 32'h0, 1'b0, 32'h0, 1'b0, "reset_p1");
            fire();
        end

        // Write r5 on port 0, read it back on both ports in the same cycle.
        slot(); set_ab(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5); settle();
        expect_ab(0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "r5_same_p0");
        expect_ab(1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "r5_same_p1");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 5, 5); settle();
        expect_ab(0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "r5_next_p0");
        expect_ab(1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "r5_next_p1");
        fire();

        // Both write ports hit r30: port 1 data wins.
        slot(); set_ab(1, 30, 32'h1111, 1, 30, 32'h2222, 0, 0, 30, 30); settle();
        expect_ab(0, 32'h2222, 1'b0, 32'h0, 1'b0, "r30_coll_same_p0");
        expect_ab(1, 32'h2222, 1'b0, 32'h0, 1'b0, "r30_coll_same_p1");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 30, 5); settle();
        expect_ab(0, 32'h2222, 1'b0, 32'h2222, 1'b0, "r30_coll_next");
        expect_ab(1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "r5_held");
        fire();

        // Register 0 ignores writes and marks.
        slot(); set_ab(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0); settle();
        expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "r0_wr_same_p0");
        expect_ab(1, 32'h0, 1'b0, 32'h0, 1'b0, "r0_wr_same_p1");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "r0_wr_next");
        fire();

        // Mark r7: not visible in the mark cycle, visible the next.
        slot(); set_ab(0, 0, 0, 0, 0, 0, 1, 7, 7, 7); settle();
        expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "r7_mark_same");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 7, 5); settle();
        expect_ab(0, 32'h0, 1'b1, 32'h0, 1'b1, "r7_mark_next");
        expect_ab(1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "r5_not_pend");
        fire();

        // Write r7: bypass hides pending this cycle; the edge clears it.
        slot(); set_ab(1, 7, 32'hA5A5, 0, 0, 0, 0, 0, 7, 7); settle();
        expect_ab(0, 32'hA5A5, 1'b0, 32'h0, 1'b1, "r7_wr_same");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 7, 7); settle();
        expect_ab(1, 32'hA5A5, 1'b0, 32'hA5A5, 1'b0, "r7_wr_next");
        fire();

        // Mark and write r7 together: data updates and the mark wins.
        slot(); set_ab(0, 0, 0, 1, 7, 32'h77, 1, 7, 7, 7); settle();
        expect_ab(0, 32'h77, 1'b0, 32'hA5A5, 1'b0, "r7_markwr_same");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 7, 7); settle();
        expect_ab(1, 32'h77, 1'b1, 32'h77, 1'b1, "r7_markwr_next");
        fire();

        // Write r3, then reset while writing r3 again: reset overrides.
        slot(); set_ab(1, 3, 32'h1234, 0, 0, 0, 0, 0, 3, 7); settle();
        expect_ab(0, 32'h1234, 1'b0, 32'h0, 1'b0, "r3_wr_same");
        fire();
        slot(); rst_n = 1'b0; set_ab(1, 3, 32'h5678, 0, 0, 0, 1, 9, 3, 7); settle();
        expect_ab(0, 32'h1234, 1'b0, 32'h1234, 1'b0, "r3_rst_nobypass");
        expect_ab(1, 32'h77, 1'b1, 32'h77, 1'b1, "r7_rst_cycle");
        fire();
        slot(); rst_n = 1'b1; set_ab(0, 0, 0, 0, 0, 0, 0, 0, 3, 7); settle();
        expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "r3_after_rst");
        expect_ab(1, 32'h0, 1'b0, 32'h0, 1'b0, "r7_after_rst");
        fire();
        slot(); set_ab(0, 0, 0, 0, 0, 0, 0, 0, 9, 5); settle();
        expect_ab(0, 32'h0, 1'b0, 32'h0, 1'b0, "r9_mark_in_rst");
        expect_ab(1, 32'h0, 1'b0, 32'h0, 1'b0, "r5_after_rst");
        fire();

        // 16-bit x 8-deep x 3-port build: reset state on every address.
        for (int i = 0; i < 8; i++) begin
            slot();
            set_c(0, 0, 0, 0, 0, 0, 0, 0, 3'(i), 3'(i + 1), 3'(i + 2));
            settle();
            for (int k = 0; k < 3; k++) expect_one(2, k, 32'h0, 1'b0, "c_reset");
            fire();
        end

        slot(); set_c(1, 3, 16'h1234, 0, 0, 0, 0, 0, 3, 3, 3); settle();
        for (int k = 0; k < 3; k++) expect_one(2, k, 32'h1234, 1'b0, "c_r3_wr");
        fire();
        slot(); rst_c = 1'b0; set_c(1, 3, 16'h5678, 0, 0, 0, 1, 2, 3, 2, 3); settle();
        expect_one(2, 0, 32'h1234, 1'b0, "c_r3_rst_cycle");
        expect_one(2, 1, 32'h0,    1'b0, "c_r2_rst_cycle");
        fire();
        slot(); rst_c = 1'b1; set_c(0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 3); settle();
        expect_one(2, 0, 32'h0, 1'b0, "c_r3_after_rst");
        expect_one(2, 1, 32'h0, 1'b0, "c_r2_after_rst");
        fire();

        slot(); set_c(1, 6, 16'hAAAA, 1, 6, 16'hBBBB, 1, 2, 6, 6, 2); settle();
        expect_one(2, 0, 32'hBBBB, 1'b0, "c_r6_coll_same");
        expect_one(2, 2, 32'h0,    1'b0, "c_r2_mark_same");
        fire();
        slot(); set_c(0, 0, 0, 0, 0, 0, 0, 0, 6, 2, 0); settle();
        expect_one(2, 0, 32'hBBBB, 1'b0, "c_r6_coll_next");
        expect_one(2, 1, 32'h0,    1'b1, "c_r2_pending");
        expect_one(2, 2, 32'h0,    1'b0, "c_r0");
        fire();
        slot(); set_c(1, 2, 16'hC0DE, 0, 0, 0, 0, 0, 2, 2, 2); settle();
        expect_one(2, 2, 32'hC0DE, 1'b0, "c_r2_wr_byp");
        fire();
        slot(); set_c(0, 0, 0, 0, 0, 0, 0, 0, 2, 6, 2); settle();
        expect_one(2, 0, 32'hC0DE, 1'b0, "c_r2_cleared");
        fire();

        slot(); #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_mp
